// File: rtl/acqbuf_pkg.sv
// Shared types and default sizes for the acquisition-buffer readout block.
package acqbuf_pkg;

  localparam int ACQ_DATAWIDTH = 32;
  localparam int ACQ_ADDRWIDTH = 12;

  typedef enum logic {
    CAPTURE = 1'b0,
    DRAIN   = 1'b1
  } acq_state_e;

endpackage

// File: rtl/acqbuf_readout_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
module sdp_ram
  import acqbuf_pkg::*;
#(
  parameter int DATAWIDTH = ACQ_DATAWIDTH,
  parameter int ADDRWIDTH = ACQ_ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0] rd_data
);

  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

  // Write port and read port; rd_data holds its value whenever rd_en is low.
  // NOTE: neither the array nor rd_data is reset, so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/acqbuf_readout.sv
// Acquisition buffer reader: captures the DSP write stream into a local RAM,
// tracks the fill level and drains words 0..count-1 over a valid/ready stream.
module acqbuf_readout
  import acqbuf_pkg::*;
#(
  parameter int DATAWIDTH = ACQ_DATAWIDTH,
  parameter int ADDRWIDTH = ACQ_ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acqbufreset,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] data,
  input  logic                 drain,
  output logic [DATAWIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [ADDRWIDTH:0]   count,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_drop
);

  localparam int CW = ADDRWIDTH + 1;

  acq_state_e           state;
  logic [CW-1:0]        rd_addr;     // next address to read during DRAIN
  logic                 rd_valid;    // RAM read register holds an unsent word
  logic                 rd_last;     // that word is the final beat
  logic                 skid_valid;  // older word parked while the host stalls
  logic                 skid_last;
  logic [DATAWIDTH-1:0] skid_data;
  logic [DATAWIDTH-1:0] ram_q;

  logic [CW-1:0]        addr_ext;
  logic [CW-1:0]        count_upd;
  logic                 wr_commit;
  logic                 rd_issue;
  logic                 issue_last;
  logic                 pop;

  // Count as it stands after this cycle's write, so a drain in the same cycle
  // covers the word being written.
  assign addr_ext   = CW'(addr) + CW'(1);
  assign count_upd  = (we && (addr_ext > count)) ? addr_ext : count;
  assign wr_commit  = we && (state == CAPTURE) && !acqbufreset;

  // A new read only starts when the skid slot is free, so the word in the RAM
  // read register always has somewhere to go if the host stalls.
  assign rd_issue   = (state == DRAIN) && (rd_addr < count) && !skid_valid;
  assign issue_last = (rd_addr == (count - CW'(1)));
  assign pop        = m_tvalid && m_tready;

  sdp_ram #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_commit),
    .wr_addr(addr),
    .wr_data(data),
    .rd_en  (rd_issue),
    .rd_addr(rd_addr[ADDRWIDTH-1:0]),
    .rd_data(ram_q)
  );

  // Stream head: the skid word (older) goes first, otherwise the RAM word.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    m_tvalid = skid_valid || rd_valid;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    if (skid_valid) begin
      m_tdata = skid_data;
      m_tlast = skid_last;
    end else if (rd_valid) begin
      m_tdata = ram_q;
      m_tlast = rd_last;
    end
  end

  // Capture/drain FSM with fill count, read pointer and skid stage.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CAPTURE;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_drop    <= 1'b0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (acqbufreset) begin
      state      <= CAPTURE;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_drop    <= 1'b0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        CAPTURE: begin
          count      <= count_upd;
          rd_addr    <= '0;
          rd_valid   <= 1'b0;
          skid_valid <= 1'b0;
          if (drain) begin
            if (count_upd != '0) begin
              state <= DRAIN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (we) wr_drop <= 1'b1;

          if (rd_issue) begin
            rd_addr  <= rd_addr + CW'(1);
            rd_valid <= 1'b1;
            rd_last  <= issue_last;
          end else if (pop && !skid_valid) begin
            rd_valid <= 1'b0;
          end

          if (skid_valid) begin
            if (pop) skid_valid <= 1'b0;
          end else if (rd_issue && rd_valid && !pop) begin
            // RAM word is about to be overwritten by the new read; park it.
            skid_valid <= 1'b1;
            skid_data  <= ram_q;
            skid_last  <= rd_last;
          end

          if (pop && m_tlast) begin
            state      <= CAPTURE;
            busy       <= 1'b0;
            done       <= 1'b1;
            count      <= '0;
            rd_valid   <= 1'b0;
            skid_valid <= 1'b0;
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_acqbuf_readout.sv
// Self-checking bench for acqbuf_readout: a memory model feeds a scoreboard
// queue of expected beats when a drain starts; a monitor pops and compares.
module tb_acqbuf_readout;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          acqbufreset;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          drain;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          wr_drop;

  int            total = 0;
  int            bad   = 0;
  int            beats = 0;
  int            done_cnt = 0;
  int            exp_count = 0;
  logic [DW-1:0] mem_model [DEPTH];
  logic [DW:0]   sb [$];
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat = '0;

  acqbuf_readout #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .acqbufreset(acqbufreset),
    .we         (we),
    .addr       (addr),
    .data       (data),
    .drain      (drain),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .wr_drop    (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge: scoreboard compare, stall stability, done count.
  always @(negedge clk) begin
    logic [DW:0] exp_item;
    if (done) done_cnt++;
    if (prev_stall && !reset) begin
      check("stall_valid", m_tvalid, 1);
      check("stall_hold", {m_tlast, m_tdata}, prev_beat);
    end
    if (m_tvalid && m_tready) begin
      beats++;
      check("beat_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_item = sb.pop_front();
        check("beat_data", m_tdata, exp_item[DW-1:0]);
        check("beat_last", m_tlast, exp_item[DW]);
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tdata};
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    we   = 1'b1;
    addr = AW'(a);
    data = d;
    mem_model[a] = d;
    if (a + 1 > exp_count) exp_count = a + 1;
    cyc();
    we = 1'b0;
  endtask

  task automatic push_drain();
    for (int i = 0; i < exp_count; i++) sb.push_back({(i == exp_count - 1), mem_model[i]});
  endtask

  task automatic start_drain();
    drain = 1'b1;
    push_drain();
    cyc();
    drain = 1'b0;
  endtask

  task automatic clear_buf();
    acqbufreset = 1'b1;
    cyc();
    acqbufreset = 1'b0;
    exp_count = 0;
    sb.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      cyc();
      n++;
    end
    check(tag, done_cnt != start, 1);
  endtask

  task automatic wait_beats(input string tag, input int target);
    int n;
    n = 0;
    while (beats < target && n < 100) begin
      cyc();
      n++;
    end
    check(tag, beats >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int b0;
    int d0;

    reset = 1'b1; acqbufreset = 1'b0; we = 1'b0; addr = '0; data = '0;
    drain = 1'b0; m_tready = 1'b1;
    cyc(2);
    check("rst_valid", m_tvalid, 0);
    check("rst_last", m_tlast, 0);
    check("rst_data", m_tdata, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", wr_drop, 0);
    reset = 1'b0;
    cyc();

    // Fill the whole RAM so every address has a known value, then clear count.
    for (int i = 0; i < DEPTH; i++) wr(i, (i * 32'h9E37_79B1) ^ 32'h0F0F_0000);
    check("fill_count", count, DEPTH);
    clear_buf();
    check("clr_count", count, 0);

    // Four words, free-flowing stream: first beat two cycles after drain.
    for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i);
    check("t1_count", count, 4);
    start_drain();
    check("t1_busy", busy, 1);
    check("t1_novalid", m_tvalid, 0);
    cyc();
    check("t1_valid0", m_tvalid, 1);
    check("t1_data0", m_tdata, 32'hA0);
    cyc(3);
    check("t1_valid3", m_tvalid, 1);
    check("t1_data3", m_tdata, 32'hA3);
    check("t1_last3", m_tlast, 1);
    cyc();
    check("t1_end_valid", m_tvalid, 0);
    check("t1_done", done, 1);
    check("t1_count0", count, 0);
    check("t1_busy0", busy, 0);
    check("t1_sb_empty", sb.size(), 0);
    exp_count = 0;

    // Same data under host back-pressure.
    for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i);
    b0 = beats;
    start_drain();
    for (int k = 0; k < 7; k++) begin
      m_tready = pat[k];
      cyc();
    end
    m_tready = 1'b1;
    wait_done("t2_done", 50);
    check("t2_beats", beats - b0, 4);
    check("t2_sb_empty", sb.size(), 0);
    exp_count = 0;

    // Write and drain in the same cycle: the write is part of the drain.
    we = 1'b1; addr = AW'(2); data = 32'h55; drain = 1'b1;
    mem_model[2] = 32'h55;
    exp_count = 3;
    push_drain();
    cyc();
    we = 1'b0; drain = 1'b0;
    check("t2b_busy", busy, 1);
    check("t2b_count", count, 3);
    wait_done("t2b_done", 50);
    check("t2b_sb_empty", sb.size(), 0);
    exp_count = 0;

    // Full-depth drain from a single write at the top address.
    wr(DEPTH - 1, 32'hDEAD_BEEF);
    check("t3_count", count, DEPTH);
    b0 = beats;
    start_drain();
    wait_done("t3_done", DEPTH + 100);
    check("t3_beats", beats - b0, DEPTH);
    check("t3_sb_empty", sb.size(), 0);
    exp_count = 0;

    // Write during drain is dropped and flagged; data stream unaffected.
    for (int i = 0; i < 8; i++) wr(i, 32'hB0 + i);
    b0 = beats;
    start_drain();
    wait_beats("t4_reach2", b0 + 2);
    we = 1'b1; addr = AW'(6); data = 32'hFFFF_FFFF;
    cyc();
    we = 1'b0;
    check("t4_drop", wr_drop, 1);
    wait_done("t4_done", 50);
    check("t4_beats", beats - b0, 8);
    check("t4_drop_sticky", wr_drop, 1);
    check("t4_count0", count, 0);
    clear_buf();
    check("t4_drop_clr", wr_drop, 0);

    // acqbufreset aborts a drain without a done pulse.
    for (int i = 0; i < 8; i++) wr(i, 32'hC0 + i);
    b0 = beats;
    start_drain();
    wait_beats("t5_reach3", b0 + 3);
    d0 = done_cnt;
    clear_buf();
    check("t5_valid0", m_tvalid, 0);
    check("t5_count0", count, 0);
    check("t5_busy0", busy, 0);
    cyc(3);
    check("t5_nodone", done_cnt, d0);
    b0 = beats;
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    check("t5_empty_done", done, 1);
    check("t5_empty_busy", busy, 0);
    cyc(4);
    check("t5_no_beats", beats, b0);
    check("t5_empty_valid", m_tvalid, 0);

    // Asynchronous reset between edges clears the stream immediately.
    for (int i = 0; i < 8; i++) wr(i, 32'hD0 + i);
    start_drain();
    cyc(3);
    check("t6_pre_valid", m_tvalid, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid0", m_tvalid, 0);
    check("t6_busy0", busy, 0);
    check("t6_count0", count, 0);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_count = 0;
    cyc(2);
    check("t6_idle_valid", m_tvalid, 0);
    check("t6_idle_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acqbuf_readout.md
Name: acqbuf_readout

Overview:
Reader end of the per-channel acquisition-buffer write port: accepts the DSP's addr/data/we write stream into a local simple-dual-port RAM and tracks the fill level. On a drain request it streams the captured words to the host in address order over a valid/ready stream with last-beat marking. One instance is built per NACQ channel on the cfg side.

Parameters:
DATAWIDTH, 32, acquisition word width (matches ACQBUF_W_DATAWIDTH)
ADDRWIDTH, 12, buffer address width; depth = 2**ADDRWIDTH

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
acqbufreset  input  1  synchronous clear; aborts any drain, count cleared
we  input  1  DSP write strobe
addr  input  ADDRWIDTH  DSP write address
data  input  DATAWIDTH  DSP write data
drain  input  1  single-cycle request to start readout
m_tdata  output  DATAWIDTH  stream data
m_tvalid  output  1  stream valid
m_tready  input  1  stream ready from host
m_tlast  output  1  marks final beat
count  output  ADDRWIDTH+1  words captured (highest written addr + 1)
busy  output  1  high while in DRAIN
done  output  1  one-cycle pulse at drain completion
wr_drop  output  1  sticky: a write arrived during DRAIN and was discarded

Behaviour:
- Reset (async): state=CAPTURE; m_tvalid=0, m_tlast=0, m_tdata=0, count=0, busy=0, done=0, wr_drop=0. RAM contents are not cleared.
- States: CAPTURE, DRAIN.
- CAPTURE:
  - we=1 writes data to RAM[addr] (1-cycle write).
  - count <= max(count, addr+1). The width is ADDRWIDTH+1 so that a full buffer reads 2**ADDRWIDTH without wrap.
- drain=1 in CAPTURE with count>0 at edge T:
  - Enter DRAIN; busy=1 from T+1.
  - RAM read of address 0 is issued at T+1.
  - m_tvalid=1 with word 0 at T+2.
- drain=1 in CAPTURE with count==0: stay in CAPTURE, done pulses at T+1, no beats are emitted.
- drain while already in DRAIN: ignored.
- DRAIN stream rules:
  - Read latency is 1 cycle; use a 2-entry skid/output stage so throughput is 1 beat/cycle while m_tready=1.
  - m_tdata and m_tlast are held stable while m_tvalid=1 and m_tready=0.
  - A beat transfers when m_tvalid and m_tready are both high.
  - Beats carry addresses 0..count-1 in order; m_tlast=1 only on beat count-1.
- Completion: on the last handshake, m_tvalid drops the next cycle, done pulses one cycle, count<=0, busy<=0, state returns to CAPTURE.
- we during DRAIN: the write is discarded and wr_drop<=1. wr_drop is cleared only by reset or acqbufreset.
- acqbufreset (synchronous, highest priority after reset), in any state, next cycle:
  - count=0, m_tvalid=0, m_tlast=0, busy=0, wr_drop=0, state=CAPTURE.
  - done is not pulsed.
  - A we in the same cycle is discarded.
- acqbufreset and drain in the same cycle: acqbufreset wins, no drain starts.
- Simultaneous we and drain in CAPTURE: the write is committed and included in count; the drain uses the updated count (count evaluated after the write).
- Unwritten addresses below count stream whatever the RAM holds; no validity tracking.

Decomposition:
- Package acqbuf_pkg: state enum (CAPTURE, DRAIN); localparam defaults for DATAWIDTH/ADDRWIDTH.
- Sub-module sdp_ram: one write port, one read port, 1-cycle registered read, inferred BRAM.
- The FSM, count, and skid stage live in acqbuf_readout.

Test Plan:
- Write addr 0..3 with 0xA0..0xA3, drain, m_tready=1 -> 4 beats 0xA0..0xA3 on consecutive cycles, first at drain+2, m_tlast on 0xA3, done pulse, count=0 after.
- Same data, m_tready pattern 1,0,0,1,0,1,1 -> order preserved, no duplicate or lost beats, data/last stable while stalled.
- Single write addr 4095 (ADDRWIDTH=12) -> count=4096; drain yields exactly 4096 beats, last on beat 4095.
- Start drain of 8 words, pulse we at beat 2 -> wr_drop=1, streamed data unchanged; acqbufreset clears wr_drop.
- acqbufreset asserted after 3 beats of 8 -> m_tvalid=0 next cycle, count=0, no done; subsequent drain with no writes -> done pulse, zero beats.
- Async reset asserted mid-drain between clock edges -> m_tvalid, busy, and count go to 0 immediately, before the next edge.
